// File: rtl/ii_rect_sum_reader.sv
// Rectangle pixel-sum reader for the integral image: four corner reads (D, B, C, A)
// combined as D - B - C + A, with out-of-bounds requests rejected up front.
module ii_rect_sum_reader #(
    parameter int II_WIDTH   = 160,
    parameter int II_HEIGHT  = 120,
    parameter int DATA_W     = 23,
    parameter int ADDR_W     = 15,
    parameter int RD_LATENCY = 2
) (
    input  logic              ov7670_pclk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [7:0]        req_x,
    input  logic [7:0]        req_y,
    input  logic [7:0]        req_w,
    input  logic [7:0]        req_h,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_sum,
    output logic              rsp_err
);
    localparam int ACC_W = DATA_W + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [7:0]                     x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [1:0]                     slot_q, slot_d;
    logic                           rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]              rd_addr_q, rd_addr_d;
    logic                           pres_vld_q, pres_vld_d, pres_msk_q, pres_msk_d;
    logic [1:0]                     pres_slot_q, pres_slot_d;
    logic [RD_LATENCY-1:0]          tag_vld_q, tag_vld_d, tag_msk_q, tag_msk_d;
    logic [RD_LATENCY-1:0][1:0]     tag_slot_q, tag_slot_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d, contrib_s, acc_sum_s;
    logic                           rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic                           req_ready_q, req_ready_d;
    logic [DATA_W-1:0]              rsp_sum_q, rsp_sum_d;
    logic                           accept_s, req_ok_s, issue_s, corner_msk_s, last_tag_s, done_hit_s;
    logic [8:0]                     x_end_s, y_end_s;
    logic [7:0]                     src_x0_s, src_y0_s, src_x1_s, src_y1_s, cx_s, cy_s;
    logic [1:0]                     nxt_slot_s;

    // y*160 + x as (y<<7) + (y<<5) + x
    function automatic logic [ADDR_W-1:0] corner_addr(input logic [7:0] cx, input logic [7:0] cy);
        logic [ADDR_W-1:0] yy;
        yy = ADDR_W'(cy);
        return (yy << 3'd7) + (yy << 3'd5) + ADDR_W'(cx);
    endfunction

    // Request handshake and 9-bit bounds check
    always_comb begin
        accept_s = req_valid && (state_q == S_IDLE);
        x_end_s  = {1'b0, req_x} + {1'b0, req_w};
        y_end_s  = {1'b0, req_y} + {1'b0, req_h};
        req_ok_s = (req_w != 8'd0) && (req_h != 8'd0) &&
                   (x_end_s <= 9'(II_WIDTH)) && (y_end_s <= 9'(II_HEIGHT));
    end

    // Corner slot selection and read strobe generation
    always_comb begin
        if (state_q == S_IDLE) begin
            src_x0_s   = req_x;
            src_y0_s   = req_y;
            src_x1_s   = req_x + req_w - 8'd1;
            src_y1_s   = req_y + req_h - 8'd1;
            nxt_slot_s = 2'd0;
        end else begin
            src_x0_s   = x0_q;
            src_y0_s   = y0_q;
            src_x1_s   = x1_q;
            src_y1_s   = y1_q;
            nxt_slot_s = slot_q + 2'd1;
        end
        case (nxt_slot_s)
            2'd0: begin cx_s = src_x1_s;        cy_s = src_y1_s;        corner_msk_s = 1'b0; end
            2'd1: begin cx_s = src_x1_s;        cy_s = src_y0_s - 8'd1; corner_msk_s = (src_y0_s == 8'd0); end
            2'd2: begin cx_s = src_x0_s - 8'd1; cy_s = src_y1_s;        corner_msk_s = (src_x0_s == 8'd0); end
            default: begin
                cx_s = src_x0_s - 8'd1;
                cy_s = src_y0_s - 8'd1;
                corner_msk_s = (src_x0_s == 8'd0) || (src_y0_s == 8'd0);
            end
        endcase
        issue_s     = (accept_s && req_ok_s) || ((state_q == S_ISSUE) && (slot_q != 2'd3));
        pres_vld_d  = issue_s;
        pres_msk_d  = issue_s && corner_msk_s;
        pres_slot_d = issue_s ? nxt_slot_s : 2'd0;
        rd_en_d     = issue_s && !corner_msk_s;
        if (rd_en_d) begin
            rd_addr_d = corner_addr(cx_s, cy_s);
        end else begin
            rd_addr_d = {ADDR_W{1'b0}};
        end
    end

    // Tag pipeline aligning returning data with its slot, and signed accumulation
    always_comb begin
        tag_vld_d[0]  = pres_vld_q;
        tag_msk_d[0]  = pres_msk_q;
        tag_slot_d[0] = pres_slot_q;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_msk_d[i]  = tag_msk_q[i-1];
            tag_slot_d[i] = tag_slot_q[i-1];
        end
        last_tag_s = tag_vld_q[RD_LATENCY-1];
        done_hit_s = last_tag_s && (tag_slot_q[RD_LATENCY-1] == 2'd3);
        if (last_tag_s && !tag_msk_q[RD_LATENCY-1]) begin
            contrib_s = $signed({2'b00, rd_data});
        end else begin
            contrib_s = {ACC_W{1'b0}};
        end
        // B and C are subtracted, D and A added
        if ((tag_slot_q[RD_LATENCY-1] == 2'd1) || (tag_slot_q[RD_LATENCY-1] == 2'd2)) begin
            acc_sum_s = acc_q - contrib_s;
        end else begin
            acc_sum_s = acc_q + contrib_s;
        end
        if (accept_s) begin
            acc_d = {ACC_W{1'b0}};
        end else if (last_tag_s) begin
            acc_d = acc_sum_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // FSM next state, request latch and response register
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s && req_ok_s) begin
                    state_d   = S_ISSUE;
                    slot_d    = 2'd0;
                    x0_d      = src_x0_s;
                    y0_d      = src_y0_s;
                    x1_d      = src_x1_s;
                    y1_d      = src_y1_s;
                    rsp_err_d = 1'b0;
                end else if (accept_s) begin
                    state_d     = S_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_sum_d   = {DATA_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (slot_q == 2'd3) begin
                    state_d = S_WAIT;
                end else begin
                    slot_d = slot_q + 2'd1;
                end
            end
            S_WAIT: begin
                if (done_hit_s) begin
                    state_d     = S_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_sum_d   = acc_sum_s[DATA_W-1:0];
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    // Registers; reset also flushes the tag pipeline so in-flight RAM data is ignored
    always_ff @(posedge ov7670_pclk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            slot_q      <= 2'd0;
            x0_q        <= 8'd0;
            y0_q        <= 8'd0;
            x1_q        <= 8'd0;
            y1_q        <= 8'd0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= {ADDR_W{1'b0}};
            pres_vld_q  <= 1'b0;
            pres_msk_q  <= 1'b0;
            pres_slot_q <= 2'd0;
            tag_vld_q   <= {RD_LATENCY{1'b0}};
            tag_msk_q   <= {RD_LATENCY{1'b0}};
            tag_slot_q  <= {(2*RD_LATENCY){1'b0}};
            acc_q       <= {ACC_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= {DATA_W{1'b0}};
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            pres_vld_q  <= pres_vld_d;
            pres_msk_q  <= pres_msk_d;
            pres_slot_q <= pres_slot_d;
            tag_vld_q   <= tag_vld_d;
            tag_msk_q   <= tag_msk_d;
            tag_slot_q  <= tag_slot_d;
            acc_q       <= acc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_err_q   <= rsp_err_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ii_rect_sum_reader.sv
// Bench for ii_rect_sum_reader: RAM model holding an integral image, a timeline model
// that predicts every output from the rectangle rules, and literal pins on directed cases.
module tb_ii_rect_sum_reader;
    localparam int W = 160, H = 120, DW = 23, AW = 15, LAT = 2;

    logic          clk = 1'b0;
    logic          rst, req_valid, req_ready, rd_en, rsp_valid, rsp_ready, rsp_err;
    logic [7:0]    req_x, req_y, req_w, req_h;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0, ram_s1 = '0, rsp_sum;

    always #5 clk = ~clk;

    ii_rect_sum_reader #(.II_WIDTH(W), .II_HEIGHT(H), .DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(LAT)) dut (
        .ov7670_pclk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_err(rsp_err));

    int n_cmp = 0, n_fail = 0;
    int pix [W*H];
    int ii_mem [W*H];
    int rd_log [$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_pattern(input int p);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                pix[y*W+x] = (p == 0) ? 1 : (p == 1) ? 255 : ((x*7 + y*13 + (x*y)%5) & 255);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                ii_mem[y*W+x] = pix[y*W+x] + ((x > 0) ? ii_mem[y*W+x-1] : 0)
                              + ((y > 0) ? ii_mem[(y-1)*W+x] : 0)
                              - ((x > 0 && y > 0) ? ii_mem[(y-1)*W+x-1] : 0);
    endtask

    function automatic int rect_sum(input int x0, input int y0, input int w, input int h);
        int s = 0;
        for (int y = y0; y < y0 + h; y++)
            for (int x = x0; x < x0 + w; x++)
                s += pix[y*W+x];
        return s;
    endfunction

    // RAM with two cycles of read latency; junk on idle cycles
    always @(posedge clk) begin
        ram_s1  <= (rd_en && rd_addr < AW'(W*H)) ? DW'(ii_mem[rd_addr]) : 23'h5A5A5;
        rd_data <= ram_s1;
    end

    always @(negedge clk) if (rd_en) rd_log.push_back(int'(rd_addr));

    // Timeline model: k counts edges since acceptance
    typedef enum {M_IDLE, M_RUN, M_RESP} mph_t;
    mph_t m_ph = M_IDLE;
    int   m_k = 0, m_sum = 0, mx, my, mw, mh;
    bit   m_err = 1'b0, m_init = 1'b0;
    int   m_addr [4];
    bit   m_msk [4];

    always @(posedge clk) begin
        if (rst) begin
            m_ph = M_IDLE;
            m_init = 1'b1;
        end else if (m_ph == M_IDLE) begin
            if (req_valid) begin
                mx = int'(req_x); my = int'(req_y); mw = int'(req_w); mh = int'(req_h);
                if (mw == 0 || mh == 0 || mx + mw > W || my + mh > H) begin
                    m_ph = M_RESP; m_err = 1'b1; m_sum = 0;
                end else begin
                    m_ph = M_RUN; m_k = 0; m_err = 1'b0;
                    m_sum = rect_sum(mx, my, mw, mh);
                    m_addr[0] = (my+mh-1)*W + mx+mw-1; m_msk[0] = 1'b0;
                    m_addr[1] = (my-1)*W + mx+mw-1;    m_msk[1] = (my == 0);
                    m_addr[2] = (my+mh-1)*W + mx-1;    m_msk[2] = (mx == 0);
                    m_addr[3] = (my-1)*W + mx-1;       m_msk[3] = (mx == 0) || (my == 0);
                end
            end
        end else if (m_ph == M_RUN) begin
            m_k++;
            if (m_k == 4 + LAT) m_ph = M_RESP;
        end else begin
            if (rsp_ready) m_ph = M_IDLE;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        bit exp_en;
        int exp_addr;
        if (m_init) begin
            exp_en = 1'b0;
            exp_addr = 0;
            if (m_ph == M_RUN && m_k <= 3) begin
                if (!m_msk[m_k]) begin
                    exp_en = 1'b1;
                    exp_addr = m_addr[m_k];
                end
            end
            check("req_ready", req_ready, m_ph == M_IDLE);
            check("rd_en", rd_en, exp_en);
            check("rd_addr", rd_addr, exp_addr);
            check("rsp_valid", rsp_valid, m_ph == M_RESP);
            if (m_ph == M_RESP) begin
                check("rsp_sum", rsp_sum, m_sum);
                check("rsp_err", rsp_err, m_err);
            end
        end
    end

    task automatic run_req(input int x, input int y, input int w, input int h,
                           input int lit_sum, input bit lit_err, input int n_rd, input int hold);
        int n = 0;
        @(posedge clk); #1;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) check("idle_timeout", 1, 0);
        rd_log.delete();
        req_valid = 1'b1; req_x = 8'(x); req_y = 8'(y); req_w = 8'(w); req_h = 8'(h);
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0; req_x = 8'hEE; req_y = 8'hEE; req_w = 8'hEE; req_h = 8'hEE;
        n = 1;
        @(negedge clk);
        while (!rsp_valid && n < 30) begin @(negedge clk); n++; end
        check("latency", n, lit_err ? 1 : 5 + LAT);
        if (lit_sum >= 0) check("sum_lit", rsp_sum, lit_sum);
        check("err_lit", rsp_err, lit_err);
        check("rd_count", rd_log.size(), n_rd);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req_valid = 1'b1; req_x = 8'd0; req_y = 8'd0; req_w = 8'd1; req_h = 8'd1;
            end
        end
        if (hold > 0) begin
            check("hold_sum", rsp_sum, lit_sum);
            check("hold_ready", req_ready, 0);
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        req_x = 8'd0; req_y = 8'd0; req_w = 8'd0; req_h = 8'd0;
        set_pattern(0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", req_ready, 1); check("rst_rd_en", rd_en, 0);
        check("rst_valid", rsp_valid, 0); check("rst_sum", rsp_sum, 0);

        run_req(0, 0, 1, 1, 1, 0, 1, 0);
        check("t1_addr", (rd_log.size() > 0) ? rd_log[0] : -1, 0);
        run_req(10, 20, 24, 24, 576, 0, 4, 0);
        if (rd_log.size() == 4) begin
            check("t2_addr_d", rd_log[0], 6913); check("t2_addr_b", rd_log[1], 3073);
            check("t2_addr_c", rd_log[2], 6889); check("t2_addr_a", rd_log[3], 3049);
        end else begin
            check("t2_addr_count", rd_log.size(), 4);
        end

        set_pattern(1);
        run_req(0, 0, 160, 120, 4896000, 0, 1, 0);
        check("t3_addr", (rd_log.size() > 0) ? rd_log[0] : -1, 19199);
        run_req(150, 0, 11, 1, 0, 1, 0, 0);
        run_req(5, 5, 0, 3, 0, 1, 0, 0);
        run_req(200, 0, 100, 1, 0, 1, 0, 0);
        run_req(0, 100, 1, 21, 0, 1, 0, 0);

        set_pattern(2);
        run_req(3, 0, 5, 4, -1, 0, 2, 0);
        run_req(0, 7, 6, 3, -1, 0, 2, 0);
        run_req(150, 110, 10, 10, -1, 0, 4, 0);
        run_req(159, 119, 1, 1, -1, 0, 4, 0);
        run_req(37, 55, 80, 41, -1, 0, 4, 0);

        set_pattern(0);
        run_req(2, 3, 4, 5, 20, 0, 4, 10);
        run_req(1, 1, 3, 3, 9, 0, 4, 0);

        // Reset pulsed three edges after acceptance
        @(posedge clk); #1;
        req_valid = 1'b1; req_x = 8'd10; req_y = 8'd20; req_w = 8'd24; req_h = 8'd24;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", req_ready, 1); check("mid_rst_rd_en", rd_en, 0);
        check("mid_rst_addr", rd_addr, 0); check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_sum", rsp_sum, 0); check("mid_rst_err", rsp_err, 0);
        run_req(1, 1, 2, 2, 4, 0, 4, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
